// File: rtl/mips_prog_loader.sv
// Boot sequencer for the MIPS core: streams instruction words into
// instruction memory, then switches the core to run mode and releases reset.
`timescale 1ns/1ps
module mips_prog_loader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              prog_mode,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              prog_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_LOAD,
    S_FLUSH,
    S_REL,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [3:0]      REL_LEN  = 4'(RST_CYCLES);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_ready;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_we;
  logic                r_cpu_rst;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W:0]     r_wc;

  state_t              w_state;
  logic [3:0]          w_cnt;
  logic                w_ready;
  logic                w_mode;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_we;
  logic                w_cpu_rst;
  logic                w_busy;
  logic                w_done;
  logic                w_err;
  logic [ADDR_W:0]     w_wc;
  logic                w_beat;
  logic                w_full;

  assign w_beat = in_valid & r_ready;
  assign w_full = (r_wc == LAST_IDX);

  // Output registers hold the values of the state being entered.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_ready   = r_ready;
    w_mode    = r_mode;
    w_addr    = r_addr;
    w_data    = r_data;
    w_we      = 1'b0;
    w_cpu_rst = r_cpu_rst;
    w_busy    = r_busy;
    w_done    = r_done;
    w_err     = r_err;
    w_wc      = r_wc;
    unique case (r_state)
      S_IDLE, S_RUN: begin
        if (start) begin
          w_state   = S_HOLD;
          w_cpu_rst = 1'b1;
          w_mode    = 1'b0;
          w_busy    = 1'b1;
          w_done    = 1'b0;
          w_err     = 1'b0;
          w_wc      = '0;
          w_ready   = 1'b0;
        end
      end
      S_HOLD: begin
        w_state   = S_LOAD;
        w_ready   = 1'b1;
        w_cpu_rst = 1'b0;
      end
      S_LOAD: begin
        if (w_beat) begin
          w_addr = r_wc[ADDR_W-1:0];
          w_data = in_data;
          w_we   = 1'b1;
          w_wc   = r_wc[ADDR_W] ? r_wc : r_wc + 1'b1;
          if (in_last || w_full) begin
            w_state = S_FLUSH;
            w_ready = 1'b0;
            w_err   = ~in_last;
          end
        end
      end
      S_FLUSH: begin
        w_state = S_REL;
        w_cnt   = '0;
      end
      S_REL: begin
        if (r_cnt == REL_LEN) begin
          w_state   = S_RUN;
          w_cpu_rst = 1'b0;
          w_done    = 1'b1;
          w_busy    = 1'b0;
        end else begin
          w_cnt     = r_cnt + 1'b1;
          w_cpu_rst = 1'b1;
          w_mode    = 1'b1;
        end
      end
      default: begin
        w_state   = S_IDLE;
        w_cpu_rst = 1'b1;
        w_mode    = 1'b0;
        w_ready   = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_mode    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wc      <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_ready   <= w_ready;
      r_mode    <= w_mode;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_we      <= w_we;
      r_cpu_rst <= w_cpu_rst;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
      r_wc      <= w_wc;
    end
  end

  assign in_ready   = r_ready;
  assign prog_mode  = r_mode;
  assign prog_addr  = r_addr;
  assign prog_data  = r_data;
  assign prog_we    = r_we;
  assign cpu_reset  = r_cpu_rst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_err;
  assign word_count = r_wc;

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Boot sequencer for the MIPS core. It owns the core's programming port (ProgMode, Addr_Prog, Data_Prog) and its reset.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to sequential instruction-memory addresses from 0.
- When the stream ends, it switches the core to run mode and releases it from reset.
- Sits between the host/debug link (UART or JTAG word source) and the MIPS top level.

Parameters:
- ADDR_W, 8, instruction-memory address width; depth = 2^ADDR_W words.
- DATA_W, 32, instruction word width.
- RST_CYCLES, 2, number of cycles cpu_reset is held high with prog_mode=1 before run; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low block reset.
- start  in  1  request a (re)load; sampled in IDLE and RUN only.
- in_valid  in  1  source has a word on in_data.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  DATA_W  instruction word.
- in_last  in  1  qualifies the final word of the program.
- prog_mode  out  1  to MIPS ProgMode; 0 = program/write, 1 = run.
- prog_addr  out  ADDR_W  to MIPS Addr_Prog.
- prog_data  out  DATA_W  to MIPS Data_Prog.
- prog_we  out  1  one-cycle write strobe, for memories that need an enable.
- cpu_reset  out  1  active-high reset to MIPS.
- busy  out  1  high in HOLD, LOAD, FLUSH and RELEASE.
- done  out  1  high in RUN.
- error  out  1  sticky truncation flag; cleared on the next accepted start.
- word_count  out  ADDR_W+1  number of words accepted in the current load.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release) forces state IDLE and these values: cpu_reset=1, prog_mode=0, prog_addr=0, prog_data=0, prog_we=0, in_ready=0, busy=0, done=0, error=0, word_count=0.
- Beat rule: a beat is accepted on a rising edge where in_valid & in_ready.

States and transitions:
- IDLE: cpu_reset=1, prog_mode=0. start -> HOLD.
- HOLD (1 cycle): cpu_reset=1, prog_mode=0. Clears word_count and error. -> LOAD.
- LOAD: cpu_reset=0, prog_mode=0, in_ready=1.
  - On each accepted beat: prog_addr <= word_count[ADDR_W-1:0], prog_data <= in_data, prog_we <= 1 (one cycle), word_count++.
  - prog_addr/prog_data hold their values until the next beat; repeated writes of the same word are harmless.
  - A beat with in_last=1 -> FLUSH; in_ready drops the next cycle.
  - A beat at word_count=2^ADDR_W-1 with in_last=0 -> FLUSH and sets error (truncation). No further words are accepted.
  - in_valid low: no state change, no timeout.
- FLUSH (1 cycle): in_ready=0. Holds prog_addr/prog_data so the final word is sampled by the memory. -> RELEASE.
- RELEASE: cpu_reset=1, prog_mode=1 for exactly RST_CYCLES cycles. -> RUN.
- RUN: cpu_reset=0, prog_mode=1, done=1. start -> HOLD (reload).

Latency and boundaries:
- Latency from the last beat edge to cpu_reset falling: 1 + 1 + RST_CYCLES cycles.
- prog_mode never changes while cpu_reset=0. The 0->1 transition occurs only on entry to RELEASE; the 1->0 transition only on entry to HOLD.
- start is ignored in HOLD, LOAD, FLUSH and RELEASE.
- start and in_valid in the same IDLE cycle: the word is not accepted (in_ready=0).
- A zero-length program is impossible; the first beat always writes address 0.
- word_count saturates at 2^ADDR_W; it does not wrap.
- reset asserted mid-LOAD: immediate return to reset values. The CPU is held in reset with prog_mode=0, and partially loaded memory contents are not cleared.

Test Plan:
- Normal load: start, then 9 back-to-back beats with data 274730462, 272629760, 270532609, 8460296, 880869382, 272760833, 6490137, 878706691, 4227858440 (in_last on the 9th) -> prog_addr steps 0..8 with matching prog_data and one prog_we per beat; word_count=9; FLUSH 1 cycle; cpu_reset=1/prog_mode=1 for 2 cycles; then RUN with done=1, error=0.
- Backpressure gaps: same program with in_valid low for 3 cycles between words 4 and 5 -> prog_addr/prog_data stay at 4/880869382 during the gap; no extra prog_we; final result identical to the normal load.
- Truncation (ADDR_W=8): 257 words, none with in_last -> 256 accepted, last at prog_addr=255, error=1, in_ready=0 after the 256th beat, RUN still reached, 257th word never accepted.
- Reset mid-load: assert reset after beat 3 -> all outputs at reset values within the same cycle; start again -> reload begins at address 0.
- Reload from RUN: start while done=1 -> HOLD with cpu_reset=1, prog_mode=0, error=0, word_count=0; new 2-word program loads at addresses 0..1.
- Ignored start: pulse start during LOAD and during RELEASE -> no state change; RELEASE length remains RST_CYCLES.
